// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and default widths for the pe feeder
// Purpose: feeder FSM state encoding and default operand/length widths.
package pe_pkg;

    localparam int BW_DEF    = 8;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        HOLD   = 3'd4
    } state_t;

endpackage

// File: rtl/pe_feeder.sv
// rtl/pe_feeder.sv - sequences one dot-product job through a pe MAC element
// Purpose: clear the pe accumulator, stream i_len activation/weight pairs into it,
//          wait out the pe pipeline, then hold the accumulator value as a result.
// Ports:
//   i_clock, i_reset_n                 clock, asynchronous active-low reset
//   i_start, i_len, o_busy             job request (taken only when idle), pair count
//   i_act_valid/i_act, i_wgt_valid/i_wgt, o_pair_ready
//                                      operand sources; a pair moves when all three high
//   o_pe_clear, o_pe_activation, o_pe_weight, i_pe_output
//                                      pe element interface
//   o_result_valid, o_result, i_result_ready
//                                      captured dot product, valid/ready handshake
module pe_feeder
    import pe_pkg::*;
#(
    parameter int BW         = BW_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int PE_LATENCY = 1
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    input  logic              i_act_valid,
    input  logic [BW-1:0]     i_act,
    input  logic              i_wgt_valid,
    input  logic [BW-1:0]     i_wgt,
    output logic              o_pair_ready,
    output logic              o_pe_clear,
    output logic [BW-1:0]     o_pe_activation,
    output logic [BW-1:0]     o_pe_weight,
    input  logic [2*BW-1:0]   i_pe_output,
    output logic              o_result_valid,
    output logic [2*BW-1:0]   o_result,
    input  logic              i_result_ready
);

    localparam int DW = $clog2(PE_LATENCY + 2);

    state_t            state;
    logic [LEN_W-1:0]  remaining;
    logic [DW-1:0]     drain_cnt;
    logic              transfer;

    // o_pair_ready is only ever set in STREAM, so it doubles as the state qualifier.
    assign transfer = o_pair_ready & i_act_valid & i_wgt_valid;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= IDLE;
            o_busy          <= 1'b0;
            o_pair_ready    <= 1'b0;
            o_pe_clear      <= 1'b1;
            o_pe_activation <= '0;
            o_pe_weight     <= '0;
            o_result_valid  <= 1'b0;
            o_result        <= '0;
            remaining       <= '0;
            drain_cnt       <= '0;
        end else begin
            // Operands default to zero so any non-transfer cycle feeds the pe 0*0.
            o_pe_clear      <= 1'b0;
            o_pe_activation <= '0;
            o_pe_weight     <= '0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        remaining  <= i_len;
                        o_pe_clear <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (remaining != '0) begin
                        o_pair_ready <= 1'b1;
                        state        <= STREAM;
                    end else begin
                        drain_cnt <= DW'(PE_LATENCY);
                        state     <= DRAIN;
                    end
                end
                STREAM: begin
                    if (transfer) begin
                        o_pe_activation <= i_act;
                        o_pe_weight     <= i_wgt;
                        remaining       <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            o_pair_ready <= 1'b0;
                            drain_cnt    <= DW'(PE_LATENCY);
                            state        <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // PE_LATENCY+1 cycles: the last operand reaches the pe one edge
                    // after its transfer, then the pe needs PE_LATENCY more.
                    if (drain_cnt == '0) begin
                        o_result       <= i_pe_output;
                        o_result_valid <= 1'b1;
                        state          <= HOLD;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                HOLD: begin
                    if (i_result_ready) begin
                        o_result_valid <= 1'b0;
                        o_busy         <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
